// File: rtl/async_fifo_rd_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO read-side controller: default
// parameters, pointer-width derivation and the Gray encode helper.
package async_fifo_rd_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH          = 8;
  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_ALMOST_EMPTY_THRESH = 4;

  // One extra pointer bit distinguishes full from empty at equal addresses.
  function automatic int unsigned ptr_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side FIFO bus: write-domain pointer in, RAM strobe/address and flags out.
interface async_fifo_rd_ctrl_if
  import async_fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  localparam int unsigned PTR_W = ptr_w(ADDR_WIDTH);

  logic [PTR_W-1:0]      wr_gray_ptr;
  logic                  rd_req;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PTR_W-1:0]      rd_gray_ptr;
  logic                  empty;
  logic                  almost_empty;
  logic [PTR_W-1:0]      rd_count;

  modport master (
    input  wr_gray_ptr, rd_req,
    output rd_en, rd_addr, rd_gray_ptr, empty, almost_empty, rd_count
  );

  modport slave (
    output wr_gray_ptr, rd_req,
    input  rd_en, rd_addr, rd_gray_ptr, empty, almost_empty, rd_count
  );

endinterface

// File: rtl/async_fifo_rd_ctrl_gray2bin.sv
// Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module async_fifo_rd_ctrl_gray2bin #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer/flag controller of a dual-clock FIFO: synchronizes the write
// Gray pointer, advances the read pointer and registers empty/almost-empty/count.
module async_fifo_rd_ctrl
  import async_fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = DEF_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned ALMOST_EMPTY_THRESH = DEF_ALMOST_EMPTY_THRESH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  async_fifo_rd_ctrl_if.master bus
);

  localparam int unsigned PTR_W = ptr_w(ADDR_WIDTH);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] wr_gray_sync;
  logic [PTR_W-1:0] wr_bin_sync;

  logic [PTR_W-1:0] rd_bin_q,   rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q,  rd_gray_d;
  logic [PTR_W-1:0] count_q,    count_d;
  logic             empty_q,    empty_d;
  logic             almost_q,   almost_d;
  logic             rd_en;

  // Plain flop chain crossing from the write clock; nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bus.wr_gray_ptr;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign wr_gray_sync = sync_q[SYNC_STAGES-1];

  async_fifo_rd_ctrl_gray2bin #(
    .WIDTH (PTR_W)
  ) u_gray2bin (
    .gray_i (wr_gray_sync),
    .bin_o  (wr_bin_sync)
  );

  assign rd_en = bus.rd_req & ~empty_q;

  // Flags are computed from the post-read pointer so the last read raises empty.
  always_comb begin
    rd_bin_d  = rd_bin_q + PTR_W'(rd_en);
    rd_gray_d = PTR_W'(bin2gray(32'(rd_bin_d)));
    count_d   = wr_bin_sync - rd_bin_d;
    empty_d   = (rd_gray_d == wr_gray_sync);
    almost_d  = (32'(count_d) <= ALMOST_EMPTY_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      almost_q  <= 1'b1;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      almost_q  <= almost_d;
    end
  end

  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = rd_bin_q[ADDR_WIDTH-1:0];
  assign bus.rd_gray_ptr  = rd_gray_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_q;
  assign bus.rd_count     = count_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomized bench for the FIFO read controller against an occupancy-level model.
module tb_async_fifo_rd_ctrl;

  localparam int unsigned AW     = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned THRESH = 4;
  localparam int          PMASK  = 31;
  localparam int          DEPTH  = 16;

  logic clk;
  logic rst_n;

  async_fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  async_fifo_rd_ctrl #(
    .ADDR_WIDTH          (AW),
    .SYNC_STAGES         (SYNC),
    .ALMOST_EMPTY_THRESH (THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: producer/consumer positions as integers, write visibility as a delay line.
  int wr_ptr;
  int m_rd;
  int m_cnt;
  bit m_empty;
  bit m_almost;
  int wq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & PMASK;
  endfunction

  task automatic model_reset();
    wr_ptr   = 0;
    m_rd     = 0;
    m_cnt    = 0;
    m_empty  = 1'b1;
    m_almost = 1'b1;
    wq.delete();
    for (int i = 0; i < int'(SYNC); i++) wq.push_back(0);
  endtask

  task automatic chk_regs();
    chk("empty",        32'(bus.empty),        32'(m_empty));
    chk("almost_empty", 32'(bus.almost_empty), 32'(m_almost));
    chk("rd_count",     32'(bus.rd_count),     32'(m_cnt));
    chk("rd_gray_ptr",  32'(bus.rd_gray_ptr),  32'(gray(m_rd)));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit req, input int wr_next);
    bit exp_en;
    int sync_v;
    bus.rd_req      = req;
    wr_ptr          = wr_next & PMASK;
    bus.wr_gray_ptr = 5'(gray(wr_ptr));
    #1;
    exp_en = req && !m_empty;
    chk("rd_en", 32'(bus.rd_en), 32'(exp_en));
    if (exp_en) chk("rd_addr", 32'(bus.rd_addr), 32'(m_rd % DEPTH));
    @(posedge clk);
    sync_v = wq.pop_front();
    wq.push_back(wr_ptr);
    if (exp_en) m_rd = (m_rd + 1) & PMASK;
    m_cnt    = (sync_v - m_rd) & PMASK;
    m_empty  = (m_cnt == 0);
    m_almost = (m_cnt <= int'(THRESH));
    @(negedge clk);
    chk_regs();
  endtask

  // Asynchronous reset asserted mid-low-phase, checked before any clock edge.
  task automatic do_reset();
    bus.rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_empty",  32'(bus.empty),        32'd1);
    chk("rst_almost", 32'(bus.almost_empty), 32'd1);
    chk("rst_rd_en",  32'(bus.rd_en),        32'd0);
    chk("rst_count",  32'(bus.rd_count),     32'd0);
    chk("rst_gray",   32'(bus.rd_gray_ptr),  32'd0);
    bus.wr_gray_ptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single_word();
    step(1'b0, 1);
    step(1'b1, 1);
    step(1'b1, 1);
    chk("one_word_count", 32'(bus.rd_count), 32'd1);
    step(1'b1, 1);
    step(1'b0, 1);
  endtask

  initial begin
    int pulses;
    rst_n           = 1'b1;
    bus.rd_req      = 1'b0;
    bus.wr_gray_ptr = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    single_word();

    // Burst of a full FIFO's worth, drained by a long request.
    step(1'b0, wr_ptr + DEPTH);
    step(1'b0, wr_ptr);
    step(1'b0, wr_ptr);
    chk("full_count", 32'(bus.rd_count), 32'(DEPTH));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (!m_empty) pulses++;
      step(1'b1, wr_ptr);
    end
    chk("burst_pulses", 32'(pulses), 32'(DEPTH));
    chk("burst_gray",   32'(bus.rd_gray_ptr), 32'(gray((1 + DEPTH) & PMASK)));

    // Random traffic, producer never overruns the true occupancy.
    for (int i = 0; i < 3000; i++) begin
      int nw;
      nw = wr_ptr;
      if ((((wr_ptr - m_rd) & PMASK) < DEPTH) && ($urandom_range(0, 99) < 55))
        nw = wr_ptr + 1;
      step(($urandom_range(0, 99) < 50), nw);
    end

    // Drain, then build occupancy 5 for the threshold checks.
    for (int i = 0; i < 24; i++) step(1'b1, wr_ptr);
    step(1'b0, wr_ptr + 5);
    step(1'b0, wr_ptr);
    step(1'b0, wr_ptr);
    chk("thr_count5",  32'(bus.rd_count),     32'd5);
    chk("thr_almost5", 32'(bus.almost_empty), 32'd0);
    step(1'b1, wr_ptr);
    chk("thr_count4",  32'(bus.rd_count),     32'd4);
    chk("thr_almost4", 32'(bus.almost_empty), 32'd1);
    step(1'b0, wr_ptr + 1);
    step(1'b0, wr_ptr);
    step(1'b0, wr_ptr);
    // Write becomes visible on the same edge as this read.
    step(1'b0, wr_ptr + 1);
    step(1'b0, wr_ptr);
    step(1'b1, wr_ptr);
    chk("simul_count",  32'(bus.rd_count),     32'd5);
    chk("simul_almost", 32'(bus.almost_empty), 32'd0);

    do_reset();
    single_word();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-side pointer and flag controller for a dual-clock FIFO; counterpart of the write-side Gray pointer counter.
- Synchronizes the write-domain Gray pointer into the read clock domain and decodes it to binary.
- Maintains the local read pointer in binary and Gray form.
- Produces the RAM read address/enable, the empty and almost-empty flags, and the fill count.
- Exports its own registered Gray read pointer back to the write domain for full detection.

Parameters:
- ADDR_WIDTH, 8, RAM address width; FIFO depth = 2^ADDR_WIDTH. Pointer width PTR_W = ADDR_WIDTH+1.
- SYNC_STAGES, 2, number of flops in the wr_gray_ptr synchronizer chain; legal values ≥ 2.
- ALMOST_EMPTY_THRESH, 4, almost_empty asserts when the registered fill count is ≤ this value.

Ports:
- clk  in  1  read-domain clock
- rst_n  in  1  asynchronous, active-low reset
- wr_gray_ptr  in  PTR_W  registered Gray write pointer from the write domain (asynchronous to clk)
- rd_req  in  1  consumer requests one word this cycle
- rd_en  out  1  RAM read strobe; rd_req & ~empty (combinational)
- rd_addr  out  ADDR_WIDTH  RAM read address; rd_bin[ADDR_WIDTH-1:0]
- rd_gray_ptr  out  PTR_W  registered Gray read pointer, to write domain
- empty  out  1  registered empty flag
- almost_empty  out  1  registered; rd_count ≤ ALMOST_EMPTY_THRESH
- rd_count  out  PTR_W  registered fill level as seen in the read domain

Behaviour:
- Reset (asynchronous, immediate):
  - Synchronizer chain, rd_bin, rd_gray_ptr and rd_count clear to 0.
  - empty and almost_empty set to 1.
  - rd_en is 0 because empty = 1.
- Synchronizer: wr_gray_sync is the last stage of a SYNC_STAGES-deep chain. No logic is placed between stages.
- Decode: wr_bin_sync = gray2bin(wr_gray_sync), combinational.
- Read pointer:
  - rd_bin_next = rd_bin + rd_en, computed modulo 2^PTR_W.
  - rd_gray_next = bin2gray(rd_bin_next).
  - On each clk edge, rd_bin takes rd_bin_next and rd_gray_ptr takes rd_gray_next.
  - rd_gray_ptr is a flop output only and changes by at most 1 bit per cycle.
- Flags, registered on the same edge as the pointer:
  - empty ← (rd_gray_next == wr_gray_sync).
  - rd_count ← (wr_bin_sync − rd_bin_next) mod 2^PTR_W.
  - almost_empty ← (count_next ≤ ALMOST_EMPTY_THRESH).
  - The last read therefore asserts empty on the same edge that consumes it, so there are no over-reads.
- Read when empty: rd_req is ignored. rd_en = 0 and the pointer holds. There is no error output.
- Data latency: RAM data for rd_addr is valid one clk after the rd_en cycle. Data handling is the RAM's concern, not this block's.
- Write-to-visible latency: a wr_gray_ptr change present before edge 0 deasserts empty after edge SYNC_STAGES (the sync chain plus the flag register).
- Simultaneous write advance and read: both are applied in the same count computation. The count may stay constant.
- Wrap-around: pointers wrap modulo 2^PTR_W with no special case.
  - Empty condition: Gray pointers are equal.
  - Full condition (write side): MSB and next-MSB inverted.
- rd_count never exceeds 2^ADDR_WIDTH when the write side is correct. No saturation logic.
- Reset mid-operation: all state clears immediately, whatever the rd_req/rd_en activity. Both FIFO domains must be reset together; this is a system requirement.

Decomposition:
- Shared header (fifo_defs.vh): PTR_W derivation, and the Gray helper include guards shared with the write side.
- Reuse the existing bin2gray for rd_gray_next.
- New sub-module gray2bin (parameter WIDTH; prefix-XOR from MSB), the decode counterpart of bin2gray. Instantiate it once for wr_bin_sync.
- The synchronizer stays inline as a generate loop. No separate module.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2, THRESH=4):
- Reset with rd_req=1, wr_gray_ptr=0 → empty=1, almost_empty=1, rd_en=0, rd_count=0, rd_gray_ptr=0.
- wr_gray_ptr 0→1 before edge 0 → empty=0 and rd_count=1 after edge 2. One-cycle rd_req gives rd_en=1 with rd_addr=0. On the next edge empty=1, rd_gray_ptr=0x01, rd_count=0.
- wr_gray_ptr=0x18 (bin 16) → rd_count=16, almost_empty=0. Holding rd_req for 20 cycles gives exactly 16 rd_en pulses, rd_addr 0..15. Then empty=1 and rd_gray_ptr=0x18.
- Wrap: after 30 writes/reads, wr_gray_ptr=0x01 (bin 1) → rd_count=3. Reads give rd_addr 14, 15, 0, then empty=1 and rd_gray_ptr=0x01.
- Threshold: rd_count 5, then one read → rd_count=4 and almost_empty=1 on the same edge. A simultaneous write plus read at count 5 → count stays 5, almost_empty=0.
- rst_n pulsed low mid-stream at rd_count=5 → all outputs return to reset values before the next clk edge. After release, behaviour matches the first scenario.
